// File: rtl/mem_sched.sv
// Main-memory transaction scheduler: icache/dcache arbitration with a dcache starvation guard.
// Optional WAIT-state timeout enabled by defining MEM_SCHED_TIMEOUT_EN.
package mem_sched_pkg;
    localparam int unsigned BLOCK_ADDR_W = 32;
    localparam int unsigned BLOCK_DATA_W = 64;

    typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0] block_data_t;

    typedef enum logic {REQ_READ = 1'b0, REQ_WRITE = 1'b1} req_type_t;
    typedef enum logic {CACHE_ICACHE = 1'b0, CACHE_DCACHE = 1'b1} cache_type_t;

    typedef struct packed {
        cache_type_t          owner;
        req_type_t            rtype;
        main_mem_block_addr_t addr;
        block_data_t          data;
    } mem_txn_t;
endpackage

module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int unsigned MAX_ICACHE_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 256
) (
    input  logic                 clk,
    input  logic                 rst_aL,
    input  logic                 icache_req_valid,
    output logic                 icache_req_ready,
    input  main_mem_block_addr_t icache_req_block_addr,
    input  logic                 dcache_req_valid,
    output logic                 dcache_req_ready,
    input  req_type_t            dcache_req_type,
    input  main_mem_block_addr_t dcache_req_block_addr,
    input  block_data_t          dcache_req_block_data,
    output logic                 mem_req_valid,
    output cache_type_t          mem_req_cache_type,
    output req_type_t            mem_req_type,
    output main_mem_block_addr_t mem_req_block_addr,
    output block_data_t          mem_req_block_data,
    input  logic                 mem_resp_valid,
    input  cache_type_t          mem_resp_cache_type,
    input  block_data_t          mem_resp_block_data,
    output logic                 icache_resp_valid,
    output block_data_t          icache_resp_block_data,
    output logic                 dcache_resp_valid,
    output block_data_t          dcache_resp_block_data,
    output logic                 busy,
    output logic                 protocol_err,
    output logic                 timeout_err
);
    localparam int unsigned STREAK_W = $clog2(MAX_ICACHE_STREAK + 1);

    if (MAX_ICACHE_STREAK < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_sched: MAX_ICACHE_STREAK and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                state_q, state_d;
    mem_txn_t              txn_q, txn_d, txn_out;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  perr_q, perr_d;
    logic                  pick_dcache;
    logic                  streak_at_max;

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  terr_q, terr_d;
`endif

    // State and latched-transaction registers
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_q    <= S_IDLE;
            txn_q      <= '0;
            streak_q   <= '0;
            perr_q     <= 1'b0;
`ifdef MEM_SCHED_TIMEOUT_EN
            wait_cnt_q <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            streak_q   <= streak_d;
            perr_q     <= perr_d;
`ifdef MEM_SCHED_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            terr_q     <= terr_d;
`endif
        end
    end

    // Arbitration, next-state and response steering
    always_comb begin
        state_d                = state_q;
        txn_d                  = txn_q;
        streak_d               = streak_q;
        perr_d                 = perr_q;
        icache_req_ready       = 1'b0;
        dcache_req_ready       = 1'b0;
        icache_resp_valid      = 1'b0;
        dcache_resp_valid      = 1'b0;
        icache_resp_block_data = '0;
        dcache_resp_block_data = '0;
        streak_at_max          = (streak_q == STREAK_W'(MAX_ICACHE_STREAK));
        pick_dcache            = dcache_req_valid && (!icache_req_valid || streak_at_max);
`ifdef MEM_SCHED_TIMEOUT_EN
        wait_cnt_d             = '0;
        terr_d                 = terr_q;
`endif

        case (state_q)
            S_IDLE: begin
                icache_req_ready = rst_aL && icache_req_valid && !pick_dcache;
                dcache_req_ready = rst_aL && pick_dcache;
                if (icache_req_ready) begin
                    txn_d.owner = CACHE_ICACHE;
                    txn_d.rtype = REQ_READ;
                    txn_d.addr  = icache_req_block_addr;
                    txn_d.data  = '0;
                    // Only icache wins taken while dcache waits count toward starvation
                    if (!dcache_req_valid) begin
                        streak_d = '0;
                    end else if (!streak_at_max) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    state_d = S_ISSUE;
                end else if (dcache_req_ready) begin
                    txn_d.owner = CACHE_DCACHE;
                    txn_d.rtype = dcache_req_type;
                    txn_d.addr  = dcache_req_block_addr;
                    txn_d.data  = (dcache_req_type == REQ_WRITE) ? dcache_req_block_data : '0;
                    streak_d    = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid && (mem_resp_cache_type == txn_q.owner)) begin
                    state_d = S_IDLE;
                    if (txn_q.owner == CACHE_ICACHE) begin
                        icache_resp_valid      = rst_aL;
                        icache_resp_block_data = rst_aL ? mem_resp_block_data : '0;
                    end else begin
                        dcache_resp_valid      = rst_aL;
                        dcache_resp_block_data = rst_aL ? mem_resp_block_data : '0;
                    end
                end else begin
                    if (mem_resp_valid) begin
                        perr_d = 1'b1;
                    end
`ifdef MEM_SCHED_TIMEOUT_EN
                    if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        terr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy               = (state_q != S_IDLE);
    assign mem_req_valid      = (state_q == S_ISSUE);
    assign txn_out            = busy ? txn_q : '0;
    assign mem_req_cache_type = txn_out.owner;
    assign mem_req_type       = txn_out.rtype;
    assign mem_req_block_addr = txn_out.addr;
    assign mem_req_block_data = txn_out.data;
    assign protocol_err       = perr_q;

`ifdef MEM_SCHED_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sched.sv
// Self-checking bench for mem_sched: directed vector table, grant-order and timeout sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_sched;
    import mem_sched_pkg::*;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic                 clk = 1'b0;
    logic                 rst_aL;
    logic                 icache_req_valid, icache_req_ready;
    main_mem_block_addr_t icache_req_block_addr;
    logic                 dcache_req_valid, dcache_req_ready;
    req_type_t            dcache_req_type;
    main_mem_block_addr_t dcache_req_block_addr;
    block_data_t          dcache_req_block_data;
    logic                 mem_req_valid;
    cache_type_t          mem_req_cache_type;
    req_type_t            mem_req_type;
    main_mem_block_addr_t mem_req_block_addr;
    block_data_t          mem_req_block_data;
    logic                 mem_resp_valid;
    cache_type_t          mem_resp_cache_type;
    block_data_t          mem_resp_block_data;
    logic                 icache_resp_valid, dcache_resp_valid;
    block_data_t          icache_resp_block_data, dcache_resp_block_data;
    logic                 busy, protocol_err, timeout_err;

    always #5 clk = ~clk;

    mem_sched #(.MAX_ICACHE_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_aL(rst_aL),
        .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
        .icache_req_block_addr(icache_req_block_addr),
        .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
        .dcache_req_type(dcache_req_type), .dcache_req_block_addr(dcache_req_block_addr),
        .dcache_req_block_data(dcache_req_block_data),
        .mem_req_valid(mem_req_valid), .mem_req_cache_type(mem_req_cache_type),
        .mem_req_type(mem_req_type), .mem_req_block_addr(mem_req_block_addr),
        .mem_req_block_data(mem_req_block_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_cache_type(mem_resp_cache_type),
        .mem_resp_block_data(mem_resp_block_data),
        .icache_resp_valid(icache_resp_valid), .icache_resp_block_data(icache_resp_block_data),
        .dcache_resp_valid(dcache_resp_valid), .dcache_resp_block_data(dcache_resp_block_data),
        .busy(busy), .protocol_err(protocol_err), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic        ir, dr, mv, mtag, mwr;
        logic [31:0] maddr;
        logic [63:0] mdata;
        logic        irv, drv;
        logic [63:0] ird, drd;
        logic        busy, perr, terr;
    } out_t;

    typedef struct packed {
        logic [5:0]  in_f;   // rst, iv, dv, dwr, rv, rtag
        logic [31:0] ia, da;
        logic [63:0] dd, rd;
        out_t        e;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string p, input out_t a, input out_t e);
        chk({p, ".icache_req_ready"}, 64'(a.ir), 64'(e.ir));
        chk({p, ".dcache_req_ready"}, 64'(a.dr), 64'(e.dr));
        chk({p, ".mem_req_valid"}, 64'(a.mv), 64'(e.mv));
        chk({p, ".mem_req_cache_type"}, 64'(a.mtag), 64'(e.mtag));
        chk({p, ".mem_req_type"}, 64'(a.mwr), 64'(e.mwr));
        chk({p, ".mem_req_block_addr"}, 64'(a.maddr), 64'(e.maddr));
        chk({p, ".mem_req_block_data"}, a.mdata, e.mdata);
        chk({p, ".icache_resp_valid"}, 64'(a.irv), 64'(e.irv));
        chk({p, ".dcache_resp_valid"}, 64'(a.drv), 64'(e.drv));
        chk({p, ".icache_resp_block_data"}, a.ird, e.ird);
        chk({p, ".dcache_resp_block_data"}, a.drd, e.drd);
        chk({p, ".busy"}, 64'(a.busy), 64'(e.busy));
        chk({p, ".protocol_err"}, 64'(a.perr), 64'(e.perr));
        chk({p, ".timeout_err"}, 64'(a.terr), 64'(e.terr));
    endtask

    function automatic out_t sample();
        out_t s;
        s.ir    = icache_req_ready;
        s.dr    = dcache_req_ready;
        s.mv    = mem_req_valid;
        s.mtag  = (mem_req_cache_type == CACHE_DCACHE);
        s.mwr   = (mem_req_type == REQ_WRITE);
        s.maddr = mem_req_block_addr;
        s.mdata = mem_req_block_data;
        s.irv   = icache_resp_valid;
        s.drv   = dcache_resp_valid;
        s.ird   = icache_resp_block_data;
        s.drd   = dcache_resp_block_data;
        s.busy  = busy;
        s.perr  = protocol_err;
        s.terr  = timeout_err;
        return s;
    endfunction

    // One clock: drive after the rising edge, sample at the falling edge.
    task automatic cyc(input logic rst, input logic iv, input logic [31:0] ia, input logic dv,
                       input logic dwr, input logic [31:0] da, input logic [63:0] dd,
                       input logic rv, input logic rtag, input logic [63:0] rd, output out_t act);
        rst_aL                = rst;
        icache_req_valid      = iv;
        icache_req_block_addr = ia;
        dcache_req_valid      = dv;
        dcache_req_type       = dwr ? REQ_WRITE : REQ_READ;
        dcache_req_block_addr = da;
        dcache_req_block_data = dd;
        mem_resp_valid        = rv;
        mem_resp_cache_type   = rtag ? CACHE_DCACHE : CACHE_ICACHE;
        mem_resp_block_data   = rd;
        @(negedge clk);
        act = sample();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [5:0] in_f, input logic [31:0] ia, input logic [31:0] da,
                                input logic [63:0] dd, input logic [63:0] rd, input logic [8:0] ex_f,
                                input logic [31:0] e_maddr, input logic [63:0] e_mdata,
                                input logic [63:0] e_ird, input logic [63:0] e_drd);
        vec_t v;
        v.in_f = in_f; v.ia = ia; v.da = da; v.dd = dd; v.rd = rd;
        v.e    = '0;
        {v.e.ir, v.e.dr, v.e.mv, v.e.mtag, v.e.mwr, v.e.irv, v.e.drv, v.e.busy, v.e.perr} = ex_f;
        v.e.maddr = e_maddr; v.e.mdata = e_mdata; v.e.ird = e_ird; v.e.drd = e_drd;
        vecs.push_back(v);
    endfunction

    // Reference model: one outstanding transaction with an age in cycles since its grant.
    task automatic run_random(input int n);
        out_t        act, e;
        logic        rst, iv, dv, dwr, rv, rtag, pick_d, hit;
        logic [31:0] ia, da;
        logic [63:0] dd, rd;
        int          m_age = -1, m_run = 0;
        logic        m_own = 1'b0, m_wr = 1'b0, m_perr = 1'b0, m_terr = 1'b0;
        logic [31:0] m_addr = '0;
        logic [63:0] m_data = '0;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);
        for (int c = 0; c < n; c++) begin
            rst  = ($urandom_range(59, 0) != 0);
            iv   = 1'($urandom_range(1, 0));
            dv   = 1'($urandom_range(1, 0));
            dwr  = 1'($urandom_range(1, 0));
            rv   = ($urandom_range(3, 0) == 0);
            rtag = 1'($urandom_range(1, 0));
            ia   = $urandom;
            da   = $urandom;
            dd   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};

            e = '0;
            pick_d = dv && (!iv || m_run >= MAXS);
            if (m_age < 0 && rst) begin
                e.ir = iv && !pick_d;
                e.dr = pick_d;
            end
            e.busy = (m_age >= 0);
            e.mv   = (m_age == 1);
            if (m_age >= 1) begin
                e.mtag = m_own; e.mwr = m_wr; e.maddr = m_addr; e.mdata = m_data;
            end
            hit   = rst && m_age >= 2 && rv && (rtag == m_own);
            e.irv = hit && !m_own;
            e.drv = hit && m_own;
            e.ird = e.irv ? rd : '0;
            e.drd = e.drv ? rd : '0;
            e.perr = m_perr;
            e.terr = m_terr;

            cyc(rst, iv, ia, dv, dwr, da, dd, rv, rtag, rd, act);
            cmp_out($sformatf("rand%0d", c), act, e);

            if (!rst) begin
                m_age = -1; m_run = 0; m_perr = 1'b0; m_terr = 1'b0;
            end else if (m_age < 0) begin
                if (e.ir || e.dr) begin
                    m_own  = e.dr;
                    m_wr   = e.dr && dwr;
                    m_addr = e.dr ? da : ia;
                    m_data = (e.dr && dwr) ? dd : '0;
                    m_run  = (e.ir && dv) ? ((m_run + 1 > MAXS) ? MAXS : m_run + 1) : 0;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (hit) begin
                m_age = -1;
            end else begin
                if (rv) m_perr = 1'b1;
`ifdef MEM_SCHED_TIMEOUT_EN
                if (m_age - 1 == TMO) begin
                    m_terr = 1'b1;
                    m_age  = -1;
                end else begin
                    m_age++;
                end
`else
                if (m_age < 1000) m_age++;
`endif
            end
        end
    endtask

    initial begin
        out_t act;
        logic own;
        logic [63:0] a5;
        a5 = {8{8'hA5}};

        //   in_f(rst iv dv dwr rv rtag)  ia  da  dd  rd | ex_f(ir dr mv mtag mwr irv drv busy perr) maddr mdata ird drd
        add(6'b010000, 32'h40, 32'h0, 64'h0, 64'h0, 9'b000000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b110000, 32'h40, 32'h0, 64'h0, 64'h0, 9'b100000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h40, 32'h0, 64'h0, 64'h0, 9'b001000010, 32'h40, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000010, 32'h40, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000010, 32'h40, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000010, 32'h40, 64'h0, 64'h0, 64'h0);
        add(6'b100010, 32'h0, 32'h0, 64'h0, a5, 9'b000001010, 32'h40, 64'h0, a5, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b101100, 32'h0, 32'h80, 64'h1234, 64'h0, 9'b010000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b001110010, 32'h80, 64'h1234, 64'h0, 64'h0);
        add(6'b100011, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000110110, 32'h80, 64'h1234, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b101000, 32'h0, 32'h100, 64'hDEAD, 64'h0, 9'b010000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b100011, 32'h0, 32'h0, 64'h0, 64'h33, 9'b001100010, 32'h100, 64'h0, 64'h0, 64'h0);
        add(6'b100010, 32'h0, 32'h0, 64'h0, 64'h77, 9'b000100010, 32'h100, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000100011, 32'h100, 64'h0, 64'h0, 64'h0);
        add(6'b100011, 32'h0, 32'h0, 64'h0, 64'h55, 9'b000100111, 32'h100, 64'h0, 64'h0, 64'h55);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000001, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b110000, 32'h200, 32'h0, 64'h0, 64'h0, 9'b100000001, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b001000011, 32'h200, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000011, 32'h200, 64'h0, 64'h0, 64'h0);
        add(6'b000000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000011, 32'h200, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b100010, 32'h0, 32'h0, 64'h0, 64'h99, 9'b000000000, 32'h0, 64'h0, 64'h0, 64'h0);
        add(6'b100000, 32'h0, 32'h0, 64'h0, 64'h0, 9'b000000000, 32'h0, 64'h0, 64'h0, 64'h0);

        #1;
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);

        foreach (vecs[i]) begin
            cyc(vecs[i].in_f[5], vecs[i].in_f[4], vecs[i].ia, vecs[i].in_f[3], vecs[i].in_f[2],
                vecs[i].da, vecs[i].dd, vecs[i].in_f[1], vecs[i].in_f[0], vecs[i].rd, act);
            cmp_out($sformatf("vec%0d", i), act, vecs[i].e);
        end

        // Both caches always valid: four icache grants, then the starved dcache.
        for (int g = 0; g < 10; g++) begin
            cyc(1'b1, 1'b1, 32'h1000 + 32'(g), 1'b1, 1'b0, 32'h2000 + 32'(g), '0, 1'b0, 1'b0, '0, act);
            chk($sformatf("order%0d.grant", g), 64'({act.ir, act.dr}), (g % 5 == 4) ? 64'd1 : 64'd2);
            own = act.dr;
            cyc(1'b1, 1'b1, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);
            chk($sformatf("order%0d.issue_tag", g), 64'({act.mv, act.mtag}), 64'({1'b1, own}));
            cyc(1'b1, 1'b1, '0, 1'b1, 1'b0, '0, '0, 1'b1, own, 64'(g), act);
            chk($sformatf("order%0d.resp", g), 64'({act.irv, act.drv}), own ? 64'd1 : 64'd2);
        end

        run_random(600);

        // No response: timeout returns to IDLE after TMO wait cycles (or waits forever).
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h300, '0, 1'b0, 1'b0, '0, act);
        chk("tmo.grant_d", 64'(act.dr), 64'd1);
        cyc(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);
        chk("tmo.issue", 64'(act.mv), 64'd1);
        for (int k = 0; k < TMO; k++) begin
            cyc(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);
            chk($sformatf("tmo.wait%0d", k), 64'({act.busy, act.ir, act.terr}), 64'b100);
        end
        cyc(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, act);
`ifdef MEM_SCHED_TIMEOUT_EN
        chk("tmo.expired", 64'({act.busy, act.ir, act.terr, act.drv}), 64'b0110);
`else
        chk("tmo.still_waiting", 64'({act.busy, act.ir, act.terr, act.drv}), 64'b1000);
        cyc(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 64'hBEEF, act);
        chk("tmo.late_resp", 64'({act.drv, act.terr}), 64'b10);
        chk("tmo.late_data", act.drd, 64'hBEEF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
